// File: rtl/muldiv_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_ctrl
//
// Execute-stage sequencer for MULT/MULTU/DIV/DIVU. It latches the operand
// magnitudes and result signs, then runs one of two engines:
//   - a fixed-latency multiplier that finishes after MUL_LAT busy cycles
//   - a 32-step restoring divider, one quotient bit per cycle
// While an operation is in progress the pipeline is frozen through 'stall'.
// When the result is ready the block spends one DONE cycle, in which it
// pulses 'hilo_we' so the HI/LO registers are written.
//
// Parameters:
//   MUL_LAT     multiplier busy cycles before DONE (1..15)
//
// Optional build macro:
//   DIV_EARLY_OUT_EN  when defined, a divide whose |dividend| < |divisor|
//                     finishes after a single DIV_RUN cycle.
//
// Ports:
//   clk, resetn        clock (rising edge) and async active-low reset
//   start              E-stage instruction valid (held while stalled)
//   ismult/signedmult  MULT or MULTU decoded / signed multiply
//   isdiv/signeddiv    DIV or DIVU decoded / signed divide
//   src_a, src_b       rs / rt operand values
//   flush              cancel the current operation
//   stall              freeze F/D/E stages
//   hilo_we            one-cycle HI/LO write strobe
//   hi_out, lo_out     HI/LO result, held between operations
//   busy               FSM not in IDLE
// ---------------------------------------------------------------------------
module muldiv_hilo_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        ismult,
  input  logic        signedmult,
  input  logic        isdiv,
  input  logic        signeddiv,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic        r_signA;
  logic        r_signB;
  logic        r_early;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic [31:0] r_rem;
  logic [31:0] r_quo;

  logic        w_req;
  logic        w_isSigned;
  logic        w_signA;
  logic        w_signB;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic        w_earlyOut;
  logic [63:0] w_prod;
  logic [63:0] w_prodRes;
  logic [32:0] w_remShift;
  logic        w_geq;
  logic [31:0] w_remSub;
  logic [31:0] w_remNext;
  logic [31:0] w_quoNext;
  logic [31:0] w_quoFinal;
  logic [31:0] w_remFinal;
  logic [31:0] w_shortRem;

  assign w_req = start & (ismult | isdiv);

  // Multiply takes priority when both decode flags are set, so its signedness
  // flag is the one that applies.
  assign w_isSigned = ismult ? signedmult : signeddiv;
  assign w_signA    = w_isSigned & src_a[31];
  assign w_signB    = w_isSigned & src_b[31];
  assign w_absA     = w_signA ? (~src_a + 32'd1) : src_a;
  assign w_absB     = w_signB ? (~src_b + 32'd1) : src_b;

`ifdef DIV_EARLY_OUT_EN
  assign w_earlyOut = (w_absB != 32'd0) && (w_absA < w_absB);
`else
  assign w_earlyOut = 1'b0;
`endif

  // Unsigned product of the magnitudes, sign restored afterwards.
  assign w_prod    = {32'd0, r_opA} * {32'd0, r_opB};
  assign w_prodRes = (r_signA ^ r_signB) ? (~w_prod + 64'd1) : w_prod;

  // One restoring step: the 33-bit shifted remainder is compared with the
  // divisor; when it fits, the difference always fits back into 32 bits.
  assign w_remShift = {r_rem, r_quo[31]};
  assign w_geq      = (w_remShift >= {1'b0, r_opB});
  assign w_remSub   = w_remShift[31:0] - r_opB;
  assign w_remNext  = w_geq ? w_remSub : w_remShift[31:0];
  assign w_quoNext  = {r_quo[30:0], w_geq};
  assign w_quoFinal = (r_signA ^ r_signB) ? (~w_quoNext + 32'd1) : w_quoNext;
  assign w_remFinal = r_signA ? (~w_remNext + 32'd1) : w_remNext;

  // Remainder for the one-cycle divide paths: re-applying the dividend sign
  // to |src_a| reproduces the original dividend bit pattern.
  assign w_shortRem = r_signA ? (~r_opA + 32'd1) : r_opA;

  assign stall   = ~flush & ((r_state == IDLE & w_req) |
                             (r_state == MUL_RUN) | (r_state == DIV_RUN));
  assign hilo_we = (r_state == DONE) & ~flush;
  assign busy    = (r_state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_count <= 5'd0;
      r_signA <= 1'b0;
      r_signB <= 1'b0;
      r_early <= 1'b0;
      r_opA   <= 32'd0;
      r_opB   <= 32'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      hi_out  <= 32'd0;
      lo_out  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !flush) begin
            r_signA <= w_signA;
            r_signB <= w_signB;
            r_opA   <= w_absA;
            r_opB   <= w_absB;
            r_rem   <= 32'd0;
            r_quo   <= w_absA;
            r_count <= 5'd0;
            r_early <= ~ismult & w_earlyOut;
            r_state <= ismult ? MUL_RUN : DIV_RUN;
          end
        end
        MUL_RUN: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_count <= r_count + 5'd1;
            if (r_count == 5'(MUL_LAT - 1)) begin
              {hi_out, lo_out} <= w_prodRes;
              r_state          <= DONE;
            end
          end
        end
        DIV_RUN: begin
          if (flush) begin
            r_state <= IDLE;
          end else if (r_opB == 32'd0) begin
            lo_out  <= 32'hFFFF_FFFF;
            hi_out  <= w_shortRem;
            r_state <= DONE;
          end else if (r_early) begin
            lo_out  <= 32'd0;
            hi_out  <= w_shortRem;
            r_state <= DONE;
          end else begin
            r_rem   <= w_remNext;
            r_quo   <= w_quoNext;
            r_count <= r_count + 5'd1;
            if (r_count == 5'd31) begin
              lo_out  <= w_quoFinal;
              hi_out  <= w_remFinal;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
